// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_responder slice: FSM state encoding,
// doubleword byte-offset width and data width.
package mem_resp_pkg;

    localparam int OFFSET_W = 3;
    localparam int DATA_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_array.sv
// Doubleword storage: synchronous write, combinational read, async clear to 0.
// Zero latency on read; no flow control, writes land on the enabled edge.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder: resp_valid LATENCY cycles after accept, held until resp_ready.
// Backpressure: req_ready only in IDLE, dropped one extra cycle after each response. Optional macro MEM_RESP_ERR_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [63:0]       req_addr,
    input  logic [63:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_rdata
`ifdef MEM_RESP_ERR_EN
    ,
    output logic              resp_err
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int LOAD  = (LATENCY >= 2) ? LATENCY - 2 : 0;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                exit_gap;
    logic                accept;
    logic                enter_resp;

    logic                lat_write;
    logic [AW-1:0]       lat_idx;
    logic [DATA_W-1:0]   lat_wdata;
    logic                lat_err;

    logic                eff_write;
    logic [AW-1:0]       eff_idx;
    logic [DATA_W-1:0]   eff_wdata;
    logic                eff_err;
    logic                req_err;

    logic                mem_wr_en;
    logic [DATA_W-1:0]   mem_rdata;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

`ifdef MEM_RESP_ERR_EN
    assign req_err = (|req_addr[OFFSET_W-1:0]) | (|req_addr[63:OFFSET_W+AW]);
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[OFFSET_W-1:0], req_addr[63:OFFSET_W+AW]};
    assign req_err     = 1'b0;
`endif

    assign req_ready  = (state == IDLE) && !exit_gap;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    // With LATENCY=1 RESP is entered on the accepting edge, so the array must
    // see the live request rather than the (not yet loaded) latches.
    assign eff_write = (state == IDLE) ? req_write : lat_write;
    assign eff_idx   = (state == IDLE) ? req_addr[OFFSET_W+AW-1:OFFSET_W] : lat_idx;
    assign eff_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign eff_err   = (state == IDLE) ? req_err : lat_err;
    assign mem_wr_en = enter_resp && eff_write && !eff_err;

    mem_array #(
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (mem_wr_en),
        .addr    (eff_idx),
        .wdata   (eff_wdata),
        .rdata   (mem_rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            exit_gap <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            exit_gap <= (state == RESP) && resp_ready;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_err   <= 1'b0;
        end else if (accept) begin
            lat_write <= req_write;
            lat_idx   <= req_addr[OFFSET_W+AW-1:OFFSET_W];
            lat_wdata <= req_wdata;
            lat_err   <= req_err;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (eff_write || eff_err) ? '0 : mem_rdata;
            err_q   <= eff_err;
        end else if ((state == RESP) && resp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    assign resp_rdata = (state == RESP) ? rdata_q : '0;

`ifdef MEM_RESP_ERR_EN
    assign resp_err = (state == RESP) && err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: DEPTH=32/LATENCY=2 main instance plus a LATENCY=1 instance for back-to-back spacing.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;

    logic        l1_req_valid, l1_req_ready, l1_req_write;
    logic [63:0] l1_req_addr, l1_req_wdata;
    logic        l1_resp_valid, l1_resp_ready;
    logic [63:0] l1_resp_rdata;

`ifdef MEM_RESP_ERR_EN
    logic        resp_err, l1_resp_err;
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam logic [63:0] D0 = 64'hDEAD_BEEF_CAFE_F00D;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(32), .LATENCY(2)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata)
`ifdef MEM_RESP_ERR_EN
        ,
        .resp_err   (resp_err)
`endif
    );

    mem_responder #(.DEPTH(32), .LATENCY(1)) u_dut_l1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_write  (l1_req_write),
        .req_addr   (l1_req_addr),
        .req_wdata  (l1_req_wdata),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_rdata (l1_resp_rdata)
`ifdef MEM_RESP_ERR_EN
        ,
        .resp_err   (l1_resp_err)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance; hold = cycles resp_ready stays low in RESP.
    task automatic txn(input logic w, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] exp_rdata, input logic exp_err, input int hold,
                       input string tag);
        int n;
        @(negedge clk);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = 64'hFFFF_FFFF_FFFF_FFF8;
        req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check({tag, "_latency"}, 64'(n), 64'd2);
        check({tag, "_rdata"}, resp_rdata, exp_rdata);
`ifdef MEM_RESP_ERR_EN
        check({tag, "_err"}, 64'(resp_err), 64'(exp_err));
`else
        if (exp_err) $display("note: %s expects an error flag that this build lacks", tag);
`endif
        // A request presented while RESP is pending must be ignored.
        req_valid = (hold > 0);
        req_write = 1'b1;
        req_addr  = 64'h10;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 64'(resp_valid), 64'd1);
            check({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_gap_req_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_gap_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_gap_rdata"}, resp_rdata, 64'd0);
    endtask

    initial begin
        logic [11:0] acc_seen, acc_exp, rv_seen, rv_exp;

        reset_n      = 1'b0;
        req_valid    = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0;
        l1_resp_ready = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_rdata", resp_rdata, 64'd0);
        check("rst_l1_req_ready", 64'(l1_req_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        txn(1'b1, 64'h10,  D0,        64'd0,                       1'b0,   0, "st_10");
        txn(1'b0, 64'h10,  64'd0,     D0,                          1'b0,   5, "ld_10_hold");
        txn(1'b1, 64'h108, 64'h1234,  64'd0,                       ERR_EN, 0, "st_108_wrap");
        txn(1'b0, 64'h8,   64'd0,     ERR_EN ? 64'd0 : 64'h1234,   1'b0,   0, "ld_8");
        txn(1'b0, 64'h13,  64'd0,     ERR_EN ? 64'd0 : D0,         ERR_EN, 0, "ld_13");

        // Reset while a store to 0x20 sits in WAIT.
        @(negedge clk);
        check("rstw_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h5555_AAAA_5555_AAAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstw_in_wait", 64'(resp_valid), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstw_req_ready_now", 64'(req_ready), 64'd1);
        check("rstw_resp_valid_now", 64'(resp_valid), 64'd0);
        check("rstw_resp_rdata_now", resp_rdata, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        txn(1'b0, 64'h20, 64'd0, 64'd0, 1'b0, 0, "ld_20_after_rst");
        txn(1'b0, 64'h10, 64'd0, 64'd0, 1'b0, 0, "ld_10_cleared");

        // LATENCY=1 back-to-back: request always offered, response always consumed.
        @(posedge clk);
        #1;
        l1_req_valid  = 1'b1;
        l1_req_write  = 1'b1;
        l1_req_addr   = 64'h40;
        l1_req_wdata  = 64'h77;
        l1_resp_ready = 1'b1;
        acc_exp = '0;
        rv_exp  = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            acc_seen[k] = l1_req_ready;
            rv_seen[k]  = l1_resp_valid;
            acc_exp[k]  = (k % 3 == 0);
            rv_exp[k]   = (k % 3 == 1);
            if (l1_resp_valid) check("l1_store_rdata", l1_resp_rdata, 64'd0);
        end
        l1_req_valid = 1'b0;
        check("l1_accept_pattern", 64'(acc_seen), 64'(acc_exp));
        check("l1_resp_pattern", 64'(rv_seen), 64'(rv_exp));

        // Load back through the LATENCY=1 instance.
        @(negedge clk);
        check("l1_ld_ready", 64'(l1_req_ready), 64'd1);
        l1_req_valid = 1'b1; l1_req_write = 1'b0;
        @(posedge clk);
        #1;
        l1_req_valid = 1'b0;
        @(negedge clk);
        check("l1_ld_valid", 64'(l1_resp_valid), 64'd1);
        check("l1_ld_rdata", l1_resp_rdata, 64'h77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 64-bit doublewords stored (power of two, >=2).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to resp_valid (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  initiator presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store (MemWrite), 0 = load (MemRead).
REQ-008 SHALL have port req_addr  input  64  byte address (ALU result).
REQ-009 SHALL have port req_wdata  input  64  store data (register read data 2).
REQ-010 SHALL have port resp_valid  output  1  response available.
REQ-011 SHALL have port resp_ready  input  1  initiator consumes the response.
REQ-012 SHALL have port resp_rdata  output  64  load data; 0 for stores.
REQ-013 SHALL have port resp_err  output  1  error flag (present only with MEM_RESP_ERR_EN).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid & req_ready.
REQ-016 On acceptance, req_write/req_addr/req_wdata SHALL be latched; later input changes are ignored until the next acceptance.
REQ-017 Acceptance SHALL go to RESP if LATENCY=1, else WAIT with a down-counter loaded to LATENCY-2.
REQ-018 WAIT SHALL decrement the counter each cycle and move to RESP on the cycle after the counter reaches 0, so resp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-019 The store write and the load read-data capture SHALL occur on the edge entering RESP.
REQ-020 In RESP, resp_valid=1 and resp_rdata/resp_err SHALL remain stable until resp_ready=1, then the FSM returns to IDLE on that edge.
REQ-021 No request SHALL be accepted in the cycle RESP exits; the earliest next acceptance is the following cycle (IDLE).
REQ-022 Word index SHALL be req_addr[3+log2(DEPTH)-1:3]; higher bits are ignored (wrap modulo DEPTH).
REQ-023 Loads SHALL return the full 64-bit doubleword; stores SHALL write all 64 bits.
REQ-024 resp_rdata SHALL be 0 outside RESP and for store responses.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and clear all storage to 0.
REQ-026 Reset mid-WAIT or mid-RESP SHALL abandon the transaction; a pending store SHALL NOT be written.

Configuration
REQ-027 With MEM_RESP_ERR_EN defined: resp_err port exists; a request with req_addr[2:0]!=0 or req_addr >= DEPTH*8 SHALL complete with normal timing, resp_err=1, resp_rdata=0, no write.
REQ-028 Without MEM_RESP_ERR_EN: no resp_err port; req_addr[2:0] is ignored and the address wraps per REQ-022.

Structure
REQ-029 A shared package mem_resp_pkg SHALL hold the FSM state enum and the constants for the byte offset width (3) and the data width (64).
REQ-030 Storage SHALL be a sub-module mem_array (synchronous write, combinational read, async clear); mem_responder holds the FSM and counter.

Verification
REQ-031 Reset then store 0xDEADBEEF_CAFEF00D at address 0x10, LATENCY=2 -> resp_valid rises 2 cycles after acceptance, resp_rdata=0; a load from 0x10 returns 0xDEADBEEF_CAFEF00D.
REQ-032 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0 throughout; req_valid ignored.
REQ-033 DEPTH=32: store 0x1234 at address 0x108 -> a load from 0x8 returns 0x1234 (wrap); with MEM_RESP_ERR_EN the same store gives resp_err=1 and the load from 0x8 returns 0.
REQ-034 With MEM_RESP_ERR_EN, a load at 0x13 -> resp_err=1, resp_rdata=0; without the macro it returns the word at 0x10.
REQ-035 Assert reset_n low during WAIT of a store to 0x20 -> outputs reset immediately; a later load from 0x20 returns 0.
REQ-036 LATENCY=1, back-to-back requests with resp_ready=1 -> resp_valid one cycle after each acceptance; acceptances spaced exactly 3 cycles apart.
